// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame size and a
// constant-width helper.
package uart_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int unsigned UART_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_SEND = SEND,
    ST_GAP  = GAP
  } state_t;

  // Ceiling log2; used for counter and index widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 64'd1;
    while (p < 64'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo N_REQ.
module rr_arbiter_comb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    grant = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = PTR_W'((32'(rr_ptr) + 32'(i)) % N_REQ);
      if (req[idx]) grant = idx;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter between N_REQ byte sources,
// with a post-byte idle gap and a watchdog against a stuck transmitter.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_byte_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int unsigned PTR_W = clog2(N_REQ);
  localparam int unsigned WD_W  = clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W = clog2(GAP_CYCLES + 1);

  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]     grant, grant_nxt;
  logic [PTR_W-1:0]     pick;
  logic                 any_req;
  logic [7:0]           data_sel, data_nxt;
  logic [N_REQ-1:0]     ready_nxt;
  logic                 byte_en_nxt, busy_nxt, terr_nxt;
  logic [WD_W-1:0]      wdog, wdog_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;

  rr_arbiter_comb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // Byte of the requester currently winning arbitration.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (PTR_W'(i) == pick) data_sel = req_data[8*i +: 8];
    end
  end

  assign grant_id = 3'(grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      tx_data     <= '0;
      req_ready   <= '0;
      tx_byte_en  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant       <= grant_nxt;
      tx_data     <= data_nxt;
      req_ready   <= ready_nxt;
      tx_byte_en  <= byte_en_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
      wdog        <= wdog_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    grant_nxt   = grant;
    data_nxt    = tx_data;
    ready_nxt   = '0;
    byte_en_nxt = 1'b0;
    terr_nxt    = timeout_err;
    wdog_nxt    = wdog;
    gap_nxt     = gap_cnt;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt       = ST_LOAD;
          grant_nxt       = pick;
          data_nxt        = data_sel;
          ready_nxt[pick] = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt   = ST_SEND;
        byte_en_nxt = 1'b1;
        wdog_nxt    = '0;
        rr_ptr_nxt  = (grant == LAST_REQ) ? '0 : grant + PTR_W'(1);
      end
      ST_SEND: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (tx_done) begin
          state_nxt = ST_GAP;
          wdog_nxt  = '0;
          gap_nxt   = '0;
        end else if (wdog == WD_LAST) begin
          state_nxt = ST_GAP;
          terr_nxt  = 1'b1;
          wdog_nxt  = '0;
          gap_nxt   = '0;
        end else begin
          byte_en_nxt = 1'b1;
          wdog_nxt    = wdog + WD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic, checked against a round-robin/timing reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_byte_en;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           busy;
  logic [2:0]     grant_id;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  // Requester-side state and reference model state.
  logic [N-1:0] valid_v;
  logic [7:0]   data_v [N];
  int           m_ptr;
  logic         m_terr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_byte_en  (tx_byte_en),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = valid_v;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = data_v[i];
  endtask

  // First requesting index at or after ptr, modulo N.
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_byte_en"},     32'(tx_byte_en),  32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // One full grant: called at #1 into an IDLE cycle with requests driven.
  // done_at < 0 means the transmitter never answers.
  task automatic run_txn(input int done_at, input bit refill);
    int         exp;
    int         len;
    int         exp_len;
    int         g;
    logic [7:0] ed;
    bit         stable;
    exp = pick(m_ptr, valid_v);
    if (exp < 0) return;
    ed = data_v[exp];

    @(posedge clk); #1;
    check("req_ready_pulse", 32'(req_ready), 32'(1 << exp));
    check("grant_id",        32'(grant_id),  32'(exp));
    check("tx_data_capture", 32'(tx_data),   32'(ed));
    check("busy_load",       32'(busy),      32'd1);
    m_ptr = (exp + 1) % N;
    if (refill) data_v[exp] = 8'($urandom);
    else        valid_v[exp] = 1'b0;
    drive();

    @(posedge clk); #1;
    check("byte_en_send",   32'(tx_byte_en), 32'd1);
    check("req_ready_drop", 32'(req_ready),  32'd0);
    len    = 0;
    stable = 1'b1;
    while (tx_byte_en === 1'b1 && len < TMO + 10) begin
      if (tx_data !== ed) stable = 1'b0;
      if (len == done_at) tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
      len++;
    end
    if (done_at >= 0 && done_at < TMO) exp_len = done_at + 1;
    else begin
      exp_len = TMO;
      m_terr  = 1'b1;
    end
    check("send_len",       32'(len),         32'(exp_len));
    check("tx_data_stable", 32'(stable),      32'd1);
    check("timeout_err",    32'(timeout_err), 32'(m_terr));
    check("busy_gap",       32'(busy),        32'd1);

    g = 0;
    while (busy === 1'b1 && g < GAP + 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("gap_len", 32'(g), 32'(GAP));
  endtask

  initial begin
    rst     = 1'b0;
    tx_done = 1'b0;
    valid_v = '0;
    for (int i = 0; i < N; i++) data_v[i] = 8'h00;
    drive();
    m_ptr  = 0;
    m_terr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Spurious tx_done while idle.
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    check("spurious_busy",    32'(busy),       32'd0);
    check("spurious_byte_en", 32'(tx_byte_en), 32'd0);
    check("spurious_ready",   32'(req_ready),  32'd0);

    // Single request.
    valid_v[2] = 1'b1; data_v[2] = 8'hA5; drive();
    run_txn(5, 1'b0);

    // Simultaneous requests on 0 and 1.
    valid_v = 4'b0011; data_v[0] = 8'h11; data_v[1] = 8'h22; drive();
    run_txn(3, 1'b0);
    run_txn(7, 1'b0);

    // Move pointer to 3, then compete 0 vs 3.
    valid_v = 4'b0100; data_v[2] = 8'h5C; drive();
    run_txn(0, 1'b0);
    valid_v = 4'b1001; data_v[0] = 8'h30; data_v[3] = 8'h33; drive();
    run_txn(2, 1'b0);
    run_txn(2, 1'b0);

    // Saturated fairness starting from pointer 0.
    valid_v = 4'b1000; data_v[3] = 8'h7E; drive();
    run_txn(1, 1'b0);
    valid_v = 4'b1111;
    for (int i = 0; i < N; i++) data_v[i] = 8'($urandom);
    drive();
    repeat (8) run_txn(int'($urandom_range(0, 4)), 1'b1);
    valid_v = '0; drive();

    // Done arriving on the last watchdog cycle is a normal completion.
    valid_v[0] = 1'b1; data_v[0] = 8'hC3; drive();
    run_txn(TMO - 1, 1'b0);

    // Watchdog abort, then normal service with the sticky flag kept.
    valid_v[1] = 1'b1; data_v[1] = 8'h99; drive();
    run_txn(-1, 1'b0);
    valid_v[2] = 1'b1; data_v[2] = 8'h42; drive();
    run_txn(4, 1'b0);

    // Randomized traffic.
    repeat (20) begin
      valid_v = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) data_v[i] = 8'($urandom);
      drive();
      run_txn(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end
    valid_v = '0; drive();
    @(posedge clk); #1;

    // Reset in the middle of SEND; pointer must restart at 0.
    valid_v = 4'b0100; data_v[2] = 8'hE7; drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid_v = 4'b1010; data_v[1] = 8'h61; data_v[3] = 8'h63; drive();
    repeat (3) @(posedge clk);
    #1;
    check("midsend_byte_en", 32'(tx_byte_en), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_ptr  = 0;
    m_terr = 1'b0;
    @(posedge clk); #1;
    check("held_reset_byte_en", 32'(tx_byte_en), 32'd0);
    @(negedge clk) rst = 1'b1;
    run_txn(2, 1'b0);
    run_txn(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between N_REQ independent byte sources using round-robin arbitration.
- Captures the granted requester's byte and holds it stable for the transmitter.
- Asserts byte_en to the transmitter, waits for tx_done, then enforces an inter-byte gap before the next grant.
- Sits between the system's message producers (status, debug, echo paths) and the byte transmitter; includes a watchdog so a stuck transmitter cannot hang the arbiter.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 16, idle clk cycles between tx_done and the next grant (>=1)
- TIMEOUT_CYCLES, 1_000_000, max clk cycles in SEND before abort (must exceed 11 bit-times at the slowest baud)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester byte available; held until accepted
- req_data  in  8*N_REQ  per-requester byte; slice i = [8*i+7:8*i]; stable while req_valid[i]
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
- tx_byte_en  out  1  start/hold to transmitter; high for the whole SEND state
- tx_data  out  8  byte to transmitter; stable while tx_byte_en high
- tx_done  in  1  transmitter completion pulse
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of the current or last granted requester
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset values: req_ready=0, tx_byte_en=0, tx_data=8'h00, busy=0, grant_id=0, timeout_err=0, state=IDLE, rr_ptr=0, all counters=0.
- States: IDLE, LOAD, SEND, GAP.
- IDLE, any req_valid high:
  - Pick the first set bit searching from rr_ptr upward, modulo N_REQ.
  - Register grant_id, capture tx_data from that requester's slice, go to LOAD.
- IDLE, no req_valid: stay in IDLE.
- LOAD (exactly 1 cycle):
  - req_ready[grant_id]=1 for this cycle only.
  - rr_ptr <= grant_id+1, wrapping from N_REQ-1 to 0.
  - Next state SEND.
- SEND:
  - tx_byte_en=1; watchdog counts up each cycle.
  - tx_done=1: drop tx_byte_en on the next cycle, clear the watchdog, go to GAP.
  - Watchdog reaches TIMEOUT_CYCLES-1 without tx_done: set timeout_err, drop tx_byte_en, go to GAP. The byte is considered consumed and is not retried.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - New requests are not sampled during GAP.
- Latency: request in IDLE at cycle t gives req_ready at t+1 and tx_byte_en high from t+2.
- Minimum spacing between consecutive grants = 2 + (SEND length) + GAP_CYCLES cycles.
- tx_done outside SEND is ignored and changes no state.
- tx_done in the same cycle the watchdog expires: treat as normal completion; timeout_err is not set.
- req_valid dropping while a request is pending but not yet accepted is legal; the arbiter re-evaluates in IDLE each cycle.
- req_valid dropping after capture has no effect on the byte in flight.
- Fairness: a requester that keeps req_valid high continuously is served at most once per N_REQ grants while others are pending.
- Reset asserted mid-SEND: all outputs return to reset values immediately (asynchronous). The in-flight byte is abandoned, and the transmitter sees byte_en fall.
- Widths:
  - Watchdog counter is ceil(log2(TIMEOUT_CYCLES)) bits.
  - GAP counter is ceil(log2(GAP_CYCLES+1)) bits.
  - grant_id is zero-extended to 3 bits.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encoding localparams: IDLE=2'd0, LOAD=2'd1, SEND=2'd2, GAP=2'd3;
  - UART_FRAME_BITS=11;
  - the clog2 helper function.
- One sub-module: rr_arbiter_comb.
  - Purely combinational round-robin pick.
  - Inputs: req vector, rr_ptr. Outputs: grant index, any_req.
  - Instantiated once; reusable by other shared-resource controllers.
- The FSM, counters and data capture stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid[2]=1, data 8'hA5 → req_ready[2] one pulse, tx_data=8'hA5, tx_byte_en high until tx_done; then busy low after GAP_CYCLES; timeout_err stays 0.
- Simultaneous requests: req_valid=4'b0011 at the same cycle, data 8'h11/8'h22 → bytes sent 8'h11 then 8'h22; grant_id 0 then 1; gap ≥16 cycles between tx_byte_en pulses.
- Saturated fairness: all four requesters held valid for 8 bytes → grant_id sequence 0,1,2,3,0,1,2,3.
- Rotation after a grant: rr_ptr=3, requests on 0 and 3 → 3 granted first, then 0.
- Watchdog: TIMEOUT_CYCLES=100, tx_done never asserted → tx_byte_en drops after 100 cycles, timeout_err=1 and remains 1; next request is still served.
- Reset and spurious done:
  - rst low mid-SEND → all outputs at reset values the same cycle; after release, a pending req_valid[1] is granted first.
  - A tx_done pulse while in IDLE causes no state change.
